decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register data, immediate and PC.
REQ-002 Parameter NREGS, default 32, architectural register count; AW = $clog2(NREGS).
REQ-003 Parameter BYPASS, default 1, enables same-cycle write-back-to-read forwarding.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  synchronous, active-low reset.
REQ-006 in_valid_i  in  1 / in_ready_o  out  1  upstream handshake from fetch.
REQ-007 instr_i  in  32 / pc_i, pc_next_4_i  in  XLEN / imm_src_i  in  imm_src_e / is_load_i  in  1  decoded load flag.
REQ-008 wb_we_i  in  1 / wb_rd_a_i  in  AW / wb_d_i  in  XLEN  write-back port.
REQ-009 flush_i  in  1  kills the held instruction.
REQ-010 out_valid_o  out  1 / out_ready_i  in  1  downstream handshake to execute.
REQ-011 rs1_d_o, rs2_d_o, imm_ext_o, pc_o, pc_next_4_o  out  XLEN; rd_a_o, rs1_a_o, rs2_a_o  out  AW; is_load_o  out  1.
REQ-012 hazard_o  out  1  load-use bubble indicator (combinational).

Function
REQ-013 Fields SHALL be rs1 = instr_i[19:15], rs2 = instr_i[24:20], rd = instr_i[11:7], truncated/zero-extended to AW.
REQ-014 in_ready_o SHALL equal (!out_valid_o | out_ready_i) & !hazard_o & !flush_i.
REQ-015 On in_valid_i & in_ready_o the output register SHALL capture all payload next edge and set out_valid_o; latency 1 cycle.
REQ-016 On out_valid_o & out_ready_i with no capture, out_valid_o SHALL clear next edge; simultaneous out-fire and in-fire SHALL replace the payload with out_valid_o held at 1.
REQ-017 While out_valid_o & !out_ready_i, all payload outputs SHALL be stable except as per REQ-021.
REQ-018 hazard_o SHALL be in_valid_i & out_valid_o & is_load_o & (rd_a_o != 0) & (rd_a_o == rs1 | rd_a_o == rs2).
REQ-019 When hazard_o & out_ready_i, out_valid_o SHALL clear (one bubble); the input is accepted the following cycle.
REQ-020 Register file: x0 reads 0, writes to x0 ignored; write commits on edge when wb_we_i; with BYPASS=1 a read of wb_rd_a_i != 0 during wb_we_i SHALL return wb_d_i.
REQ-021 Snoop: when out_valid_o, no capture this cycle, wb_we_i, wb_rd_a_i != 0 and wb_rd_a_i equals rs1_a_o (rs2_a_o), rs1_d_o (rs2_d_o) SHALL update to wb_d_i next edge.
REQ-022 imm_ext_o SHALL be sign-extended per imm_src_i (I/S/B/U/J) to XLEN.
REQ-023 flush_i SHALL take priority over capture and hold: next edge out_valid_o = 0, all payload = 0, address outputs = 0; register file writes still occur.
REQ-024 Flush and write-back in the same cycle SHALL both take effect.

Reset
REQ-025 While rst_ni = 0 at an edge: out_valid_o = 0, all payload outputs 0, all register-file entries 0; in_ready_o SHALL be 0 during reset.
REQ-026 Reset mid-transfer SHALL discard the held instruction with no partial state.

Structure
REQ-027 imm_src_e, XLEN default and reg-index constants SHALL live in definitions_pkg.
REQ-028 Register file with bypass SHALL be sub-module regfile_bypass (params XLEN, NREGS, BYPASS); immediate generation SHALL reuse extend_imm.

Verification
REQ-029 Write x5=0x1234 via WB, then decode add x6,x5,x5 with out_ready_i=1 -> next cycle out_valid_o=1, rs1_d_o=rs2_d_o=0x1234, rd_a_o=6.
REQ-030 Same-cycle WB x7=0xAA and decode reading x7 (BYPASS=1) -> rs1_d_o=0xAA; BYPASS=0 -> old value 0.
REQ-031 lw x8 held in output, next instr reads x8 -> hazard_o=1, in_ready_o=0, one cycle out_valid_o=0, consumer accepted next cycle.
REQ-032 out_ready_i=0 for 3 cycles with held rs1_a_o=9, WB x9=0x55 -> rs1_d_o=0x55, other payload unchanged, out_valid_o stays 1.
REQ-033 flush_i asserted with in_valid_i=1 and out_valid_o=1 -> next cycle out_valid_o=0, all payload 0, input not captured.
REQ-034 Read of x0 after WB to x0 of 0xFFFF -> rs1_d_o=0; rst_ni=0 mid-stream -> all outputs 0 next edge.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared decode-stage definitions: immediate formats, width defaults,
// instruction field positions and the immediate generator.
package definitions_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = 32;
  localparam int RD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;
  localparam int REG_FIELD_W = 5;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  // Produces the 32-bit sign-extended immediate; callers widen it to XLEN.
  function automatic logic signed [31:0] extend_imm(input logic [31:0] instr,
                                                    input imm_src_e   src);
    logic signed [31:0] imm;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write architectural register file with hardwired x0 and
// optional forwarding of the write port onto the read ports.
module regfile_bypass
  import definitions_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // x0 wins over forwarding so a write aimed at x0 never leaks through.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (rd_addr1 == '0)
      rd_data1 = '0;
    else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1))
      rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (rd_addr2 == '0)
      rd_data2 = '0;
    else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2))
      rd_data2 = wr_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: operand read, immediate generation and a single skid-free
// output register toward execute, with load-use bubble and write-back snoop.
module decode_stage
  import definitions_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_next_4_i,
  input  imm_src_e        imm_src_i,
  input  logic            is_load_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_rd_a_i,
  input  logic [XLEN-1:0] wb_d_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] rs1_d_o,
  output logic [XLEN-1:0] rs2_d_o,
  output logic [XLEN-1:0] imm_ext_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_4_o,
  output logic [AW-1:0]   rd_a_o,
  output logic [AW-1:0]   rs1_a_o,
  output logic [AW-1:0]   rs2_a_o,
  output logic            is_load_o,
  output logic            hazard_o
);

  logic [AW-1:0]      rs1_a_p0, rs2_a_p0, rd_a_p0;
  logic [XLEN-1:0]    rs1_d_p0, rs2_d_p0;
  logic signed [31:0] imm32_p0;
  logic [XLEN-1:0]    imm_ext_p0;
  logic               capture;

  logic               vld_p1;
  logic [XLEN-1:0]    rs1_d_p1, rs2_d_p1, imm_ext_p1, pc_p1, pc_next_4_p1;
  logic [AW-1:0]      rd_a_p1, rs1_a_p1, rs2_a_p1;
  logic               is_load_p1;

  // ---- p0: field extraction, operand read, immediate ----
  assign rs1_a_p0   = AW'(instr_i[RS1_LSB +: REG_FIELD_W]);
  assign rs2_a_p0   = AW'(instr_i[RS2_LSB +: REG_FIELD_W]);
  assign rd_a_p0    = AW'(instr_i[RD_LSB  +: REG_FIELD_W]);
  assign imm32_p0   = extend_imm(instr_i, imm_src_i);
  assign imm_ext_p0 = XLEN'(imm32_p0);

  regfile_bypass #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_en    (wb_we_i),
    .wr_addr  (wb_rd_a_i),
    .wr_data  (wb_d_i),
    .rd_addr1 (rs1_a_p0),
    .rd_addr2 (rs2_a_p0),
    .rd_data1 (rs1_d_p0),
    .rd_data2 (rs2_d_p0)
  );

  assign hazard_o = in_valid_i & vld_p1 & is_load_p1 & (rd_a_p1 != '0) &
                    ((rd_a_p1 == rs1_a_p0) | (rd_a_p1 == rs2_a_p0));

  assign in_ready_o = rst_ni & (!vld_p1 | out_ready_i) & !hazard_o & !flush_i;
  assign capture    = in_valid_i & in_ready_o;

  // ---- p1: output register toward execute ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      vld_p1       <= 1'b0;
      rs1_d_p1     <= '0;
      rs2_d_p1     <= '0;
      imm_ext_p1   <= '0;
      pc_p1        <= '0;
      pc_next_4_p1 <= '0;
      rd_a_p1      <= '0;
      rs1_a_p1     <= '0;
      rs2_a_p1     <= '0;
      is_load_p1   <= 1'b0;
    end else if (capture) begin
      vld_p1       <= 1'b1;
      rs1_d_p1     <= rs1_d_p0;
      rs2_d_p1     <= rs2_d_p0;
      imm_ext_p1   <= imm_ext_p0;
      pc_p1        <= pc_i;
      pc_next_4_p1 <= pc_next_4_i;
      rd_a_p1      <= rd_a_p0;
      rs1_a_p1     <= rs1_a_p0;
      rs2_a_p1     <= rs2_a_p0;
      is_load_p1   <= is_load_i;
    end else begin
      if (vld_p1 && out_ready_i) vld_p1 <= 1'b0;
      // A held instruction must observe write-backs that land after it was read.
      if (vld_p1 && wb_we_i && (wb_rd_a_i != '0)) begin
        if (wb_rd_a_i == rs1_a_p1) rs1_d_p1 <= wb_d_i;
        if (wb_rd_a_i == rs2_a_p1) rs2_d_p1 <= wb_d_i;
      end
    end
  end

  assign out_valid_o = vld_p1;
  assign rs1_d_o     = rs1_d_p1;
  assign rs2_d_o     = rs2_d_p1;
  assign imm_ext_o   = imm_ext_p1;
  assign pc_o        = pc_p1;
  assign pc_next_4_o = pc_next_4_p1;
  assign rd_a_o      = rd_a_p1;
  assign rs1_a_o     = rs1_a_p1;
  assign rs2_a_o     = rs2_a_p1;
  assign is_load_o   = is_load_p1;

endmodule
